// File: rtl/dataflow_ctrl_seq.sv
// Start/ready/done sequencer for a dataflow region: NPROC head processes started together, one tail process.
// Optional stall watchdog compiled in when DF_STALL_WATCHDOG_EN is defined; otherwise stall_flag is tied low.
module dataflow_ctrl_seq #(
   parameter int          NPROC    = 2,
   parameter int          CNT_W    = 2,
   parameter logic [15:0] WD_LIMIT = 16'd1000
) (
   input  logic             ap_clk,
   input  logic             ap_rst,
   input  logic             ap_start,
   output logic             ap_ready,
   output logic             ap_done,
   input  logic             ap_continue,
   output logic             ap_idle,
   output logic [NPROC-1:0] proc_start,
   input  logic [NPROC-1:0] proc_ready,
   input  logic [NPROC:0]   proc_idle,
   input  logic             tail_done,
   output logic             tail_continue,
   output logic             stall_flag
);

   localparam logic [CNT_W-1:0] MAX_OUT = '1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_FULL
   } state_t;

   state_t           w_state;
   logic [NPROC-1:0] r_ready_count;
   logic [CNT_W-1:0] r_out_cnt;
   logic             r_done_hold;
   logic             w_full;
   logic             w_all_ready;
   logic             w_done_fire;
   logic             w_inc;
   logic             w_dec;

   // Occupancy state is derived purely from the outstanding-iteration count.
   always_comb begin
      w_state = ST_RUN;
      if (r_out_cnt == '0) begin
         w_state = ST_IDLE;
      end else if (r_out_cnt == MAX_OUT) begin
         w_state = ST_FULL;
      end
   end

   assign w_full        = (w_state == ST_FULL);
   assign proc_start    = {NPROC{ap_start & ~w_full}} & ~r_ready_count;
   assign w_all_ready   = &(r_ready_count | proc_ready);
   assign ap_ready      = ap_start & ~w_full & w_all_ready;
   assign ap_done       = tail_done | r_done_hold;
   assign w_done_fire   = ap_done & ap_continue;
   assign w_inc         = ap_ready & ~w_done_fire;
   assign w_dec         = w_done_fire & ~ap_ready & (w_state != ST_IDLE);
   assign tail_continue = ap_continue;
   assign ap_idle       = (w_state == ST_IDLE) & ~r_done_hold & (&proc_idle);

   // A head that already accepted the current iteration is masked until every head has.
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         r_ready_count <= '0;
      end else if (ap_ready) begin
         r_ready_count <= '0;
      end else begin
         r_ready_count <= r_ready_count | (proc_start & proc_ready);
      end
   end

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         r_out_cnt <= '0;
      end else if (w_inc) begin
         r_out_cnt <= r_out_cnt + 1'b1;
      end else if (w_dec) begin
         r_out_cnt <= r_out_cnt - 1'b1;
      end
   end

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         r_done_hold <= 1'b0;
      end else if (ap_continue) begin
         r_done_hold <= 1'b0;
      end else if (tail_done) begin
         r_done_hold <= 1'b1;
      end
   end

`ifdef DF_STALL_WATCHDOG_EN
   logic [15:0] r_wd_cnt;
   logic        r_stall;
   logic        w_progress;

   // Any handshake activity, or having nothing outstanding, counts as progress.
   assign w_progress = (w_state == ST_IDLE) | (|proc_ready) | tail_done;

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         r_wd_cnt <= '0;
         r_stall  <= 1'b0;
      end else begin
         if (w_progress) begin
            r_wd_cnt <= '0;
         end else if (r_wd_cnt != 16'hFFFF) begin
            r_wd_cnt <= r_wd_cnt + 16'd1;
         end
         if (r_wd_cnt == WD_LIMIT) begin
            r_stall <= 1'b1;
         end
      end
   end

   assign stall_flag = r_stall;
`else
   assign stall_flag = 1'b0;
`endif

endmodule

// File: doc/dataflow_ctrl_seq.md
DATAFLOW_CTRL_SEQ -- requirements
Module: dataflow_ctrl_seq

Interface
REQ-001 SHALL have parameter NPROC, default 2, number of head processes started in parallel by the top-level start.
REQ-002 SHALL have parameter CNT_W, default 2, width of the outstanding-iteration counter; MAX_OUT = 2^CNT_W - 1.
REQ-003 SHALL have parameter WD_LIMIT, default 16'd1000, stall watchdog threshold in cycles.
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 ap_clk  in  1  sole clock, all state updates on rising edge.
REQ-006 ap_rst  in  1  synchronous active-high reset.
REQ-007 ap_start  in  1  top-level start request.
REQ-008 ap_ready  out  1  top-level iteration accepted by all head processes.
REQ-009 ap_done  out  1  top-level iteration complete, held until ap_continue.
REQ-010 ap_continue  in  1  downstream accepts ap_done.
REQ-011 ap_idle  out  1  no outstanding iterations and all processes idle.
REQ-012 proc_start  out  NPROC  per-head ap_start.
REQ-013 proc_ready  in  NPROC  per-head ap_ready.
REQ-014 proc_idle  in  NPROC+1  per-process ap_idle; bit NPROC is the tail process.
REQ-015 tail_done  in  1  tail-process ap_done.
REQ-016 tail_continue  out  1  tail-process ap_continue.
REQ-017 stall_flag  out  1  sticky watchdog indication.

Function
REQ-018 ready_count[i] (1 bit per head) SHALL set on proc_start[i] & proc_ready[i] & ~ap_ready and clear on ap_ready.
REQ-019 proc_start[i] SHALL equal ap_start & ~ready_count[i] & ~full, where full = (out_cnt == MAX_OUT).
REQ-020 ap_ready SHALL equal ap_start & ~full & AND-reduce over i of (ready_count[i] | proc_ready[i]), combinational, zero latency.
REQ-021 out_cnt SHALL increment on ap_ready & ~done_fire, decrement on done_fire & ~ap_ready, hold when both or neither; done_fire = ap_done & ap_continue.
REQ-022 When full, ap_ready and all proc_start SHALL be 0; no increment beyond MAX_OUT.
REQ-023 done_fire with out_cnt == 0 and no simultaneous ap_ready SHALL NOT wrap; counter holds 0.
REQ-024 done_hold SHALL set on tail_done & ~ap_continue and clear on ap_continue; ap_done = tail_done | done_hold.
REQ-025 tail_continue SHALL equal ap_continue.
REQ-026 ap_idle SHALL equal (out_cnt == 0) & ~done_hold & AND-reduce(proc_idle), combinational.
REQ-027 Derived state: IDLE (out_cnt 0), RUN (0 < out_cnt < MAX_OUT), FULL (out_cnt == MAX_OUT); transitions only via REQ-021.
REQ-028 ap_start deasserted with some ready_count set SHALL retain ready_count until a later ap_ready; no head is restarted for the same iteration.

Reset
REQ-029 On ap_rst: ready_count 0, out_cnt 0, done_hold 0, watchdog counter 0, stall_flag 0.
REQ-030 During and after reset cycle: ap_ready 0 unless inputs drive REQ-020; ap_done = tail_done; no registered output carries pre-reset state.
REQ-031 Reset mid-iteration SHALL abandon outstanding iterations; out_cnt returns to 0.

Configuration
REQ-032 Macro DF_STALL_WATCHDOG_EN defined: 16-bit wd_cnt increments each cycle with out_cnt != 0 and no proc_ready bit, no tail_done; clears on any such event; at wd_cnt == WD_LIMIT stall_flag sets, sticky until ap_rst; wd_cnt saturates.
REQ-033 Macro undefined: no watchdog logic; stall_flag tied to 0.

Verification
REQ-034 NPROC=2, ap_start=1, proc_ready=2'b11 same cycle -> ap_ready=1 that cycle, out_cnt 0->1.
REQ-035 proc_ready=2'b01 cycle 0, 2'b10 cycle 2 -> proc_start[0]=0 cycles 1-2, ap_ready=1 only cycle 2, ready_count cleared cycle 3.
REQ-036 CNT_W=2, 3 accepted iterations, no done -> out_cnt=3, ap_ready=0, proc_start=0 despite ap_start=1 and proc_ready=2'b11.
REQ-037 tail_done pulse with ap_continue=0 for 4 cycles -> ap_done=1 for 4 cycles; ap_continue=1 -> out_cnt decrements, ap_done=0 next cycle.
REQ-038 ap_ready and done_fire same cycle at out_cnt=2 -> out_cnt stays 2; then ap_rst -> out_cnt=0, ap_idle=1 with proc_idle all 1.
REQ-039 DF_STALL_WATCHDOG_EN, WD_LIMIT=16, out_cnt=1, no progress 16 cycles -> stall_flag=1 and stays 1 after tail_done.
